// File: rtl/uart_word_loader.sv
// uart_word_loader: 8N1 UART receiver that packs bytes little-endian into 32-bit words and
// strobes them to program ROM / data RAM. Optional idle timeout via `UPG_IDLE_TIMEOUT_EN.
module uart_word_loader #(
    parameter int CLKS_PER_BIT   = 87,
    parameter int WORD_COUNT     = 32768,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_n_i,
    input  logic        upg_rx_i,
    output logic        upg_clk_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_frame_err_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [14:0]      LAST_ADR = 15'(WORD_COUNT - 1);

    if (CLKS_PER_BIT < 4 || WORD_COUNT < 1 || WORD_COUNT > 32768 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_word_loader: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    logic             rx_meta_q, rx_s_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid;
    logic             frame_err_q, frame_err_d;

    logic [31:0]      word_q, word_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [14:0]      wptr_q, wptr_d;
    logic [14:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             wen_q, wen_d;
    logic             done_q, done_d;

`ifdef UPG_IDLE_TIMEOUT_EN
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              seen_byte_q, seen_byte_d;
`endif

    assign upg_clk_o = upg_clk_i;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge upg_clk_i) begin
        if (!upg_rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= upg_rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // RX bit-timing FSM
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_valid  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) byte_valid  = 1'b1;
                    else        frame_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word assembler, write pointer and completion
    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        wptr_d     = wptr_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wen_d      = 1'b0;
        done_d     = done_q;
        if (byte_valid && !done_q) begin
            word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                wen_d  = 1'b1;
                dat_d  = {shift_q, word_q[23:0]};
                adr_d  = wptr_q;
                wptr_d = wptr_q + 15'd1;
                if (wptr_q == LAST_ADR) done_d = 1'b1;
            end
        end
`ifdef UPG_IDLE_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
        seen_byte_d = seen_byte_q | (byte_valid & ~done_q);
        if (state_q != IDLE) begin
            idle_cnt_d = '0;
        end else if (seen_byte_q && !done_q) begin
            if (idle_cnt_q == IDLE_LAST) begin
                done_d     = 1'b1;
                byte_idx_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge upg_clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!upg_rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            wptr_q      <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            wptr_q      <= wptr_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
        end
    end

`ifdef UPG_IDLE_TIMEOUT_EN
    always_ff @(posedge upg_clk_i) begin
        if (!upg_rst_n_i) begin
            idle_cnt_q  <= '0;
            seen_byte_q <= 1'b0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            seen_byte_q <= seen_byte_d;
        end
    end
`endif

    assign upg_wen_o       = wen_q;
    assign upg_adr_o       = adr_q;
    assign upg_dat_o       = dat_q;
    assign upg_done_o      = done_q;
    assign upg_frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed self-checking bench for uart_word_loader (CLKS_PER_BIT=8, WORD_COUNT=2).
// The idle-timeout step runs only when UPG_IDLE_TIMEOUT_EN is defined.
module tb_uart_word_loader;

    localparam int C = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        upg_clk;
    logic        wen;
    logic [14:0] adr;
    logic [31:0] dat;
    logic        done;
    logic        frame_err;

    uart_word_loader #(
        .CLKS_PER_BIT  (C),
        .WORD_COUNT    (2),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .upg_clk_i      (clk),
        .upg_rst_n_i    (rst_n),
        .upg_rx_i       (rx),
        .upg_clk_o      (upg_clk),
        .upg_wen_o      (wen),
        .upg_adr_o      (adr),
        .upg_dat_o      (dat),
        .upg_done_o     (done),
        .upg_frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Strobe / frame-error log, sampled on the falling edge.
    int          wen_cnt = 0;
    int          fe_cnt  = 0;
    logic [14:0] adr_log[$];
    logic [31:0] dat_log[$];
    logic        done_log[$];
    int          cyc_log[$];
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            adr_log.push_back(adr);
            dat_log.push_back(dat);
            done_log.push_back(done);
            cyc_log.push_back(cyc);
            wen_cnt++;
        end
        if (frame_err === 1'b1) fe_cnt++;
    end

    int errors = 0;
    int checks = 0;
    int start_cyc = 0;
    int w0, f0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_wen"},  32'(wen), 32'd0);
        check({tag, "_adr"},  32'(adr), 32'd0);
        check({tag, "_dat"},  dat, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop_bit;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    initial begin
        // Reset state
        do_reset("rst0");
        @(negedge clk);
        check("clk_passthrough_low", 32'(upg_clk), 32'd0);

        // Single word 0x12345678 at adr 0
        w0 = wen_cnt;
        send_word(32'h1234_5678);
        check("single_wen_count", 32'(wen_cnt - w0), 32'd1);
        if (wen_cnt > w0) begin
            check("single_adr", 32'(adr_log[w0]), 32'h0);
            check("single_dat", dat_log[w0], 32'h1234_5678);
            // 2 sync + 1 detect + 5 start + 64 data + 8 stop cycles -> strobe 80 cycles after start bit
            check("single_latency", 32'(cyc_log[w0] - start_cyc), 32'd80);
            check("single_done", 32'(done_log[w0]), 32'd0);
        end
        check("single_hold_dat", dat, 32'h1234_5678);
        check("single_wen_low", 32'(wen), 32'd0);

        // Two consecutive words reach WORD_COUNT; a third word is ignored
        do_reset("rst1");
        w0 = wen_cnt;
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0001);
        check("pair_wen_count", 32'(wen_cnt - w0), 32'd2);
        if (wen_cnt >= w0 + 2) begin
            check("pair_a_adr", 32'(adr_log[w0]), 32'h0);
            check("pair_a_dat", dat_log[w0], 32'hDEAD_BEEF);
            check("pair_a_done", 32'(done_log[w0]), 32'd0);
            check("pair_b_adr", 32'(adr_log[w0+1]), 32'h1);
            check("pair_b_dat", dat_log[w0+1], 32'h0000_0001);
            check("pair_b_done", 32'(done_log[w0+1]), 32'd1);
        end
        send_word(32'hCAFE_F00D);
        check("done_no_more_wen", 32'(wen_cnt - w0), 32'd2);
        check("done_adr_frozen", 32'(adr), 32'h1);
        check("done_dat_frozen", dat, 32'h0000_0001);
        check("done_sticky", 32'(done), 32'd1);
        f0 = fe_cnt;
        send_byte(8'h00, 1'b0);
        check("done_ferr_pulse", 32'(fe_cnt - f0), 32'd1);

        // Start-bit glitch, then a clean word
        do_reset("rst2");
        w0 = wen_cnt;
        f0 = fe_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (C / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * C) @(negedge clk);
        check("glitch_no_wen", 32'(wen_cnt - w0), 32'd0);
        check("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);
        send_word(32'hD4C3_B2A1);
        check("glitch_wen_count", 32'(wen_cnt - w0), 32'd1);
        check("glitch_adr", 32'(adr), 32'h0);
        check("glitch_dat", dat, 32'hD4C3_B2A1);

        // Framing error discards the byte without advancing the byte index
        do_reset("rst3");
        w0 = wen_cnt;
        f0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        check("ferr_count", 32'(fe_cnt - f0), 32'd1);
        check("ferr_no_wen", 32'(wen_cnt - w0), 32'd0);
        send_word(32'h4433_2211);
        check("ferr_then_wen_count", 32'(wen_cnt - w0), 32'd1);
        check("ferr_then_adr", 32'(adr), 32'h0);
        check("ferr_then_dat", dat, 32'h4433_2211);
        check("ferr_no_extra", 32'(fe_cnt - f0), 32'd1);

        // Reset after two bytes and part of a third
        do_reset("rst4");
        w0 = wen_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * C) @(negedge clk);
        do_reset("rst_mid");
        check("midreset_no_wen", 32'(wen_cnt - w0), 32'd0);
        send_word(32'h0403_0201);
        check("midreset_wen_count", 32'(wen_cnt - w0), 32'd1);
        check("midreset_adr", 32'(adr), 32'h0);
        check("midreset_dat", dat, 32'h0403_0201);

`ifdef UPG_IDLE_TIMEOUT_EN
        // One byte then idle: done after 5000 idle cycles, no strobe
        do_reset("rst5");
        w0 = wen_cnt;
        send_byte(8'h5A, 1'b1);
        repeat (4850) @(negedge clk);
        check("timeout_not_yet", 32'(done), 32'd0);
        repeat (300) @(negedge clk);
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_no_wen", 32'(wen_cnt - w0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
